// File: rtl/eth_vlan_strip.sv
// Removes one 802.1Q tag (frame bytes 12..15) from AXI-Stream frames and repacks the remainder.
// Reports the stripped VID/PCP per frame on a status sideband.
module eth_vlan_strip #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter logic [15:0] TPID       = 16'h8100
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_strip_en,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic                      stat_valid,
  output logic                      stat_stripped,
  output logic [11:0]               stat_vlan_id,
  output logic [2:0]                stat_pcp,
  output logic [31:0]               stat_strip_count
);

  localparam int unsigned KEEP_W = DATA_WIDTH / 8;
  localparam int unsigned HALF_W = DATA_WIDTH / 2;

  generate
    if (DATA_WIDTH != 64) begin : g_bad_width
      $error("eth_vlan_strip: only DATA_WIDTH == 64 is supported");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_FIRST,
    ST_SECOND,
    ST_PASS,
    ST_STRIP,
    ST_FLUSH
  } state_t;

  state_t                state;
  logic                  en_q;
  logic                  frame_stripped;
  logic [HALF_W-1:0]     hold;
  logic [11:0]           vid_q;
  logic [2:0]            pcp_q;
  logic [KEEP_W/2-1:0]   flush_keep;

  logic                  s_fire_c;
  logic                  m_fire_c;
  logic                  tag_hit_c;
  logic                  out_free_c;

  // Output register may be reloaded when empty or draining this cycle.
  assign out_free_c    = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = out_free_c && (state != ST_FLUSH);
  assign s_fire_c      = s_axis_tvalid && s_axis_tready;
  assign m_fire_c      = m_axis_tvalid && m_axis_tready;

  // Beat 1 lanes 4/5 hold frame bytes 12/13; a full non-last beat 1 guarantees the whole tag is present.
  assign tag_hit_c = en_q && !s_axis_tlast && (s_axis_tkeep == KEEP_W'('1)) &&
                     (s_axis_tdata[39:32] == TPID[15:8]) &&
                     (s_axis_tdata[47:40] == TPID[7:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_FIRST;
      en_q             <= 1'b0;
      frame_stripped   <= 1'b0;
      hold             <= '0;
      vid_q            <= '0;
      pcp_q            <= '0;
      flush_keep       <= '0;
      m_axis_tdata     <= '0;
      m_axis_tkeep     <= '0;
      m_axis_tvalid    <= 1'b0;
      m_axis_tlast     <= 1'b0;
      stat_valid       <= 1'b0;
      stat_stripped    <= 1'b0;
      stat_vlan_id     <= '0;
      stat_pcp         <= '0;
      stat_strip_count <= '0;
    end else begin
      if (m_fire_c) m_axis_tvalid <= 1'b0;
      stat_valid <= 1'b0;

      unique case (state)
        ST_FIRST: begin
          if (s_fire_c) begin
            m_axis_tdata   <= s_axis_tdata;
            m_axis_tkeep   <= s_axis_tkeep;
            m_axis_tlast   <= s_axis_tlast;
            m_axis_tvalid  <= 1'b1;
            en_q           <= cfg_strip_en;
            frame_stripped <= 1'b0;
            vid_q          <= '0;
            pcp_q          <= '0;
            if (!s_axis_tlast) state <= ST_SECOND;
          end
        end

        ST_SECOND: begin
          if (s_fire_c) begin
            if (tag_hit_c) begin
              vid_q          <= {s_axis_tdata[51:48], s_axis_tdata[63:56]};
              pcp_q          <= s_axis_tdata[55:53];
              hold           <= s_axis_tdata[HALF_W-1:0];
              frame_stripped <= 1'b1;
              state          <= ST_STRIP;
            end else begin
              m_axis_tdata  <= s_axis_tdata;
              m_axis_tkeep  <= s_axis_tkeep;
              m_axis_tlast  <= s_axis_tlast;
              m_axis_tvalid <= 1'b1;
              state         <= s_axis_tlast ? ST_FIRST : ST_PASS;
            end
          end
        end

        ST_PASS: begin
          if (s_fire_c) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tkeep  <= s_axis_tkeep;
            m_axis_tlast  <= s_axis_tlast;
            m_axis_tvalid <= 1'b1;
            if (s_axis_tlast) state <= ST_FIRST;
          end
        end

        ST_STRIP: begin
          // Lower half of each input beat completes the output beat; upper half is carried.
          if (s_fire_c) begin
            m_axis_tdata  <= {s_axis_tdata[HALF_W-1:0], hold};
            hold          <= s_axis_tdata[DATA_WIDTH-1:HALF_W];
            m_axis_tvalid <= 1'b1;
            if (!s_axis_tlast) begin
              m_axis_tkeep <= KEEP_W'('1);
              m_axis_tlast <= 1'b0;
            end else if (!s_axis_tkeep[KEEP_W/2]) begin
              m_axis_tkeep <= {s_axis_tkeep[KEEP_W/2-1:0], (KEEP_W/2)'('1)};
              m_axis_tlast <= 1'b1;
              state        <= ST_FIRST;
            end else begin
              m_axis_tkeep <= KEEP_W'('1);
              m_axis_tlast <= 1'b0;
              flush_keep   <= s_axis_tkeep[KEEP_W-1:KEEP_W/2];
              state        <= ST_FLUSH;
            end
          end
        end

        ST_FLUSH: begin
          // Output tlast is only ever set here once the trailing beat has been loaded.
          if (m_fire_c && m_axis_tlast) begin
            state <= ST_FIRST;
          end else if (out_free_c && !m_axis_tlast) begin
            m_axis_tdata  <= {HALF_W'(0), hold};
            m_axis_tkeep  <= {(KEEP_W/2)'(0), flush_keep};
            m_axis_tlast  <= 1'b1;
            m_axis_tvalid <= 1'b1;
          end
        end

        default: state <= ST_FIRST;
      endcase

      // Frame status: reads the pre-update frame flags, so a new beat 0 in the same cycle is harmless.
      if (m_fire_c && m_axis_tlast) begin
        stat_valid    <= 1'b1;
        stat_stripped <= frame_stripped;
        stat_vlan_id  <= vid_q;
        stat_pcp      <= pcp_q;
        if (frame_stripped && (stat_strip_count != 32'hFFFF_FFFF))
          stat_strip_count <= stat_strip_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_eth_vlan_strip.sv
// Self-checking bench for eth_vlan_strip: table of frames, byte-level reference model and scoreboard.
module tb_eth_vlan_strip;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_strip_en;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        stat_valid;
  logic        stat_stripped;
  logic [11:0] stat_vlan_id;
  logic [2:0]  stat_pcp;
  logic [31:0] stat_strip_count;

  eth_vlan_strip dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_strip_en     (cfg_strip_en),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tlast     (s_axis_tlast),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .stat_valid       (stat_valid),
    .stat_stripped    (stat_stripped),
    .stat_vlan_id     (stat_vlan_id),
    .stat_pcp         (stat_pcp),
    .stat_strip_count (stat_strip_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [15:0] tpid;      // 0 = no tag inserted
    logic [15:0] tci;
    bit          en;
    bit          toggle;
    logic [31:0] pl;
    bit          exp_strip;
    logic [11:0] exp_vid;
    logic [2:0]  exp_pcp;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    bit          last;
    bit          flush;
  } beat_t;

  typedef struct {
    bit          stripped;
    logic [11:0] vid;
    logic [2:0]  pcp;
    logic [31:0] cnt;
  } stat_t;

  beat_t       exp_q[$];
  stat_t       stat_q[$];
  logic [7:0]  frame_b[$];
  logic [7:0]  out_b[$];
  int          checks = 0;
  int          failures = 0;
  int          model_cnt = 0;
  bit          toggle = 1'b0;
  bit          sb_off = 1'b0;
  vec_t        vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Downstream ready: constant 1, or toggling every cycle when requested.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = toggle ? ~m_axis_tready : 1'b1;
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  beat_t       mon_e;
  stat_t       mon_s;
  bit          stall_prev = 1'b0;
  logic [63:0] stall_data;
  logic [8:0]  stall_ctl;
  logic [63:0] mask;

  always @(negedge clk) begin
    if (rst_n && !sb_off) begin
      if (stall_prev && m_axis_tvalid) begin
        chk("stall_data", m_axis_tdata, stall_data);
        chk("stall_keep_last", {m_axis_tkeep, m_axis_tlast}, 64'(stall_ctl));
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_data = m_axis_tdata;
      stall_ctl  = {m_axis_tkeep, m_axis_tlast};
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(m_axis_tkeep), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          for (int i = 0; i < 8; i++) mask[8*i +: 8] = mon_e.keep[i] ? 8'hFF : 8'h00;
          chk("beat_data", m_axis_tdata & mask, mon_e.data);
          chk("beat_keep", 64'(m_axis_tkeep), 64'(mon_e.keep));
          chk("beat_last", 64'(m_axis_tlast), 64'(mon_e.last));
          if (mon_e.flush) chk("flush_s_tready", 64'(s_axis_tready), 64'd0);
        end
      end
      if (stat_valid) begin
        if (stat_q.size() == 0) begin
          chk("unexpected_stat", 64'(stat_valid), 64'd0);
        end else begin
          mon_s = stat_q.pop_front();
          chk("stat_stripped", 64'(stat_stripped), 64'(mon_s.stripped));
          chk("stat_vlan_id", 64'(stat_vlan_id), 64'(mon_s.vid));
          chk("stat_pcp", 64'(stat_pcp), 64'(mon_s.pcp));
          chk("stat_count", 64'(stat_strip_count), 64'(mon_s.cnt));
        end
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic build_frame(input vec_t v);
    int i;
    frame_b.delete();
    for (int j = 0; j < 6; j++) frame_b.push_back(v.tpid != 16'h0 ? 8'(8'hAA + j * 8'h11) : 8'hFF);
    for (int j = 0; j < 6; j++) frame_b.push_back(v.tpid != 16'h0 ? 8'(8'h10 * (j + 1)) : 8'(8'h11 * j));
    if (v.tpid != 16'h0) begin
      frame_b.push_back(v.tpid[15:8]);
      frame_b.push_back(v.tpid[7:0]);
      frame_b.push_back(v.tci[15:8]);
      frame_b.push_back(v.tci[7:0]);
    end
    frame_b.push_back(8'h08);
    frame_b.push_back(8'h00);
    i = 0;
    while (frame_b.size() < v.len) begin
      frame_b.push_back(i < 4 ? v.pl[31 - 8 * i -: 8] : 8'(i * 7 + 3));
      i++;
    end
    while (frame_b.size() > v.len) void'(frame_b.pop_back());
  endtask

  // Reference: drop bytes 12..15 when stripped, then pack into 8-byte beats.
  task automatic push_expected(input vec_t v);
    beat_t b;
    stat_t s;
    int    last_k;
    out_b.delete();
    for (int j = 0; j < frame_b.size(); j++)
      if (!(v.exp_strip && j >= 12 && j <= 15)) out_b.push_back(frame_b[j]);
    last_k = ((v.len - 1) % 8) + 1;
    for (int base = 0; base < out_b.size(); base += 8) begin
      b.data = '0;
      b.keep = '0;
      for (int j = 0; j < 8; j++) begin
        if (base + j < out_b.size()) begin
          b.data[8*j +: 8] = out_b[base + j];
          b.keep[j] = 1'b1;
        end
      end
      b.last  = (base + 8 >= out_b.size());
      b.flush = b.last && v.exp_strip && (last_k > 4);
      exp_q.push_back(b);
    end
    if (v.exp_strip) model_cnt++;
    s.stripped = v.exp_strip;
    s.vid      = v.exp_strip ? v.exp_vid : 12'h0;
    s.pcp      = v.exp_strip ? v.exp_pcp : 3'h0;
    s.cnt      = 32'(model_cnt);
    stat_q.push_back(s);
  endtask

  // Drives frame_b; limit > 0 sends only that many beats (no tlast).
  task automatic send_frame(input int limit);
    int total, nb, n;
    total = (frame_b.size() + 7) / 8;
    nb = (limit > 0 && limit < total) ? limit : total;
    for (int b = 0; b < nb; b++) begin
      s_axis_tdata = '0;
      s_axis_tkeep = '0;
      for (int j = 0; j < 8; j++) begin
        if (b * 8 + j < frame_b.size()) begin
          s_axis_tdata[8*j +: 8] = frame_b[b * 8 + j];
          s_axis_tkeep[j] = 1'b1;
        end
      end
      s_axis_tlast  = (b == total - 1);
      s_axis_tvalid = 1'b1;
      n = 0;
      while (!s_axis_tready && n < 2000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 2000) begin
        chk("s_tready_timeout", 64'd0, 64'd1);
        s_axis_tvalid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || stat_q.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(exp_q.size() + stat_q.size()), 64'd0);
    toggle = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_frame(input vec_t v, input bit do_drain);
    build_frame(v);
    push_expected(v);
    cfg_strip_en = v.en;
    toggle = v.toggle;
    send_frame(0);
    if (do_drain) drain();
  endtask

  initial begin
    //          len  tpid      tci       en  tog pl            strip vid     pcp
    vecs[0]  = '{18, 16'h0000, 16'h0000, 1, 0, 32'hDEADBEEF, 0, 12'h000, 3'd0};
    vecs[1]  = '{22, 16'h8100, 16'h0005, 1, 0, 32'hCAFEBABE, 1, 12'h005, 3'd0};
    vecs[2]  = '{20, 16'h8100, 16'hA00C, 1, 0, 32'h12345678, 1, 12'h00C, 3'd5};
    vecs[3]  = '{22, 16'h8100, 16'h0005, 0, 0, 32'hCAFEBABE, 0, 12'h000, 3'd0};
    vecs[4]  = '{22, 16'h8100, 16'h0005, 1, 1, 32'hCAFEBABE, 1, 12'h005, 3'd0};
    vecs[5]  = '{16, 16'h8100, 16'h0123, 1, 0, 32'h00000000, 0, 12'h000, 3'd0};
    vecs[6]  = '{64, 16'h8100, 16'hE123, 1, 0, 32'h01020304, 1, 12'h123, 3'd7};
    vecs[7]  = '{61, 16'h8100, 16'h2FFF, 1, 1, 32'hA5A5A5A5, 1, 12'hFFF, 3'd1};
    vecs[8]  = '{60, 16'h8100, 16'h4ABC, 1, 0, 32'h11223344, 1, 12'hABC, 3'd2};
    vecs[9]  = '{8,  16'h0000, 16'h0000, 1, 0, 32'h00000000, 0, 12'h000, 3'd0};
    vecs[10] = '{30, 16'h88A8, 16'h0456, 1, 0, 32'h55667788, 0, 12'h000, 3'd0};
    vecs[11] = '{15, 16'h8100, 16'h0456, 1, 0, 32'h00000000, 0, 12'h000, 3'd0};
    vecs[12] = '{40, 16'h8100, 16'h6321, 1, 1, 32'h99AABBCC, 1, 12'h321, 3'd3};

    rst_n = 1'b0;
    cfg_strip_en = 1'b0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_stat_valid", 64'(stat_valid), 64'd0);
    chk("rst_stat_count", 64'(stat_strip_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_frame(vecs[i], 1'b1);

    // Back-to-back: stripped frame with trailing beat, immediately followed by an untagged one.
    run_frame(vecs[1], 1'b0);
    run_frame(vecs[0], 1'b1);

    // Reset while mid-strip of a 64-byte tagged frame.
    sb_off = 1'b1;
    build_frame(vecs[6]);
    cfg_strip_en = 1'b1;
    send_frame(4);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("midrst_m_tdata", m_axis_tdata, 64'd0);
    chk("midrst_m_keep_last", 64'({m_axis_tkeep, m_axis_tlast}), 64'd0);
    chk("midrst_stat", 64'({stat_valid, stat_stripped, stat_vlan_id, stat_pcp}), 64'd0);
    chk("midrst_count", 64'(stat_strip_count), 64'd0);
    exp_q.delete();
    stat_q.delete();
    model_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sb_off = 1'b0;
    run_frame(vecs[0], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_vlan_strip.md
Name: eth_vlan_strip

Overview:
Sits directly downstream of ethernet_frame_parser on the AXI-Stream datapath. Removes a single 802.1Q tag (4 bytes at frame offsets 12..15) from each tagged frame and re-packs the rest of the frame by shifting it down 4 bytes. Untagged frames pass through unmodified. Reports the stripped VID/PCP on a per-frame status sideband for the forwarding stage.

Parameters:
DATA_WIDTH, 64, stream width in bits; only 64 is supported, and elaboration fails on any other value.
TPID, 16'h8100, tag protocol identifier to match; byte 12 must equal TPID[15:8] and byte 13 must equal TPID[7:0].

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
cfg_strip_en  in  1  enables stripping; sampled when beat 0 of a frame is accepted
s_axis_tdata  in  64  input data; frame byte i of a beat is at tdata[8*i +: 8]
s_axis_tkeep  in  8  byte enables for the input beat
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  last beat of the input frame
m_axis_tdata  out  64  output data
m_axis_tkeep  out  8  output byte enables
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  last beat of the output frame
stat_valid  out  1  one-cycle pulse when the output tlast beat is accepted
stat_stripped  out  1  the frame just completed had its tag removed
stat_vlan_id  out  12  VID of the stripped tag; 0 when not stripped
stat_pcp  out  3  PCP of the stripped tag; 0 when not stripped
stat_strip_count  out  32  number of frames stripped; saturates at 32'hFFFFFFFF

Behaviour:
- Input rules: tkeep is all-ones on non-last beats. On the last beat, tkeep is nonzero and contiguous from lane 0. Any other tkeep pattern gives undefined output.
- Output stage: a single register slice. Handshake: s_axis_tready = (!m_axis_tvalid || m_axis_tready) && state != FLUSH.
- Latency: 1 cycle for beat 0 and for all passthrough beats. In STRIP, each output beat appears 1 cycle after the input beat that completes it.
- State FIRST (reset state):
  - Accept beat 0 and forward it unchanged.
  - Latch en = cfg_strip_en.
  - If tlast, stay in FIRST; otherwise go to SECOND.
- State SECOND: on acceptance of beat 1, strip the tag only if all of these hold:
  - en = 1
  - tlast = 0
  - tkeep = 8'hFF
  - lane4 == TPID[15:8] and lane5 == TPID[7:0]
  When stripping:
  - Capture VID = {lane6[3:0], lane7} and PCP = lane6[7:5].
  - Set hold = lanes 0..3 of beat 1. Nothing is output this cycle.
  - Go to STRIP.
  When not stripping: forward beat 1 unchanged, then go to PASS (or FIRST if tlast).
- State PASS: forward beats unchanged; return to FIRST on the accepted tlast beat.
- State STRIP: each accepted beat `in` with keep count k produces output {in[31:0], hold}, then hold <= in[63:32].
  - Not last: keep = 8'hFF, tlast = 0.
  - Last with k <= 4: keep = (1 << (4+k)) - 1, tlast = 1, go to FIRST.
  - Last with k > 4: keep = 8'hFF, tlast = 0, go to FLUSH.
- State FLUSH: s_axis_tready = 0. Emit {32'h0, hold} with keep = (1 << (k-4)) - 1 and tlast = 1. When it is accepted, go to FIRST.
- Frames of 16 bytes or fewer, or frames with a partial beat 1, are never stripped.
- Stats:
  - stat_valid pulses for 1 cycle on the cycle the output tlast beat handshakes.
  - stat_stripped, stat_vlan_id and stat_pcp describe that frame and hold their values until the next pulse.
  - stat_strip_count increments on that same cycle when the frame was stripped.
- Output stability: while m_axis_tvalid = 1 and m_axis_tready = 0, m_axis_tdata, m_axis_tkeep and m_axis_tlast stay stable.
- Reset (including mid-frame):
  - All outputs go to 0, the state returns to FIRST, and hold, VID and PCP are cleared.
  - Any partially sent frame is abandoned without tlast; downstream tolerates this.
  - The first input beat after reset is treated as beat 0.

Test Plan:
- Untagged 18B frame (dst FF×6, src 00..55, type 0800, payload DEADBEEF) -> 3 output beats identical to the input; last beat keep 8'h03; stat_stripped = 0.
- Tagged 22B frame (dst AA..FF, src 10..60, 8100, TCI 0005, 0800, payload CAFEBABE) ->
  - beat 0 = AA BB CC DD EE FF 10 20;
  - beat 1 = 30 40 50 60 08 00 CA FE, keep FF;
  - FLUSH beat = BA BE, keep 8'h03, tlast;
  - stat_vlan_id = 12'd5, stat_pcp = 0, count = 1.
- Tagged 20B frame with TCI A00C -> 16B output; last beat keep FF, tlast, no FLUSH beat; stat_vlan_id = 12'h00C, stat_pcp = 5.
- Tagged 22B frame with cfg_strip_en = 0 -> 22B passthrough; stat_stripped = 0; count unchanged.
- Tagged 22B frame with m_axis_tready toggled 1/0 every cycle -> same bytes as scenario 2, no data change while stalled, s_axis_tready = 0 during FLUSH.
- rst_n asserted during STRIP of a 64B tagged frame, then an untagged 18B frame sent -> outputs 0 during reset; the 18B frame passes through intact; count = 0.
